// File: rtl/tilt_gesture_encoder_if.sv
// Sample-in / command-out bundle between the tilt sensor front end and the
// gesture encoder. The master drives samples; the slave returns commands.
interface tilt_gesture_if;
    logic              sample_valid;
    logic signed [7:0] tilt_x;
    logic signed [7:0] tilt_y;
    logic        [3:0] sw;
    logic        [7:0] gesture_count;
    logic              busy;

    modport master (
        output sample_valid, tilt_x, tilt_y,
        input  sw, gesture_count, busy
    );

    modport slave (
        input  sample_valid, tilt_x, tilt_y,
        output sw, gesture_count, busy
    );
endinterface

// File: rtl/tilt_gesture_encoder.sv
// Turns held head-tilt gestures into one fixed-length one-hot sw pulse each,
// requiring a return to neutral before the next gesture is accepted.
module tilt_gesture_encoder #(
    parameter int THRESH       = 40,
    parameter int HYST         = 8,
    parameter int HOLD_SAMPLES = 4,
    parameter int PULSE_CYCLES = 16
) (
    input  logic           clk,
    input  logic           reset,
    tilt_gesture_if.slave  bus
);
    localparam logic [7:0] THRESH_L  = 8'(THRESH);
    localparam logic [7:0] NEUTRAL_L = 8'(THRESH - HYST);
    localparam logic [3:0] HOLD_L    = 4'(HOLD_SAMPLES);
    localparam logic [7:0] PULSE_L   = 8'(PULSE_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        EMIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t     state_reg;
    logic [1:0] cand_reg;
    logic [3:0] hold_reg;
    logic [7:0] pulse_reg;
    logic [3:0] sw_reg;
    logic [7:0] count_reg;
    logic       busy_reg;

    logic [7:0] raw_x;
    logic [7:0] raw_y;
    logic [7:0] mag_x;
    logic [7:0] mag_y;
    logic       x_wins;
    logic [7:0] max_mag;
    logic       tilted;
    logic       neutral;
    logic [1:0] dir;
    logic [3:0] cand_onehot;

    assign raw_x = bus.tilt_x;
    assign raw_y = bus.tilt_y;

    // Unsigned 8-bit negation maps -128 to 128, so no saturation is needed.
    assign mag_x = raw_x[7] ? (8'd0 - raw_x) : raw_x;
    assign mag_y = raw_y[7] ? (8'd0 - raw_y) : raw_y;

    assign x_wins  = (mag_x >= mag_y);
    assign max_mag = x_wins ? mag_x : mag_y;
    assign tilted  = (max_mag >= THRESH_L);
    assign neutral = (mag_x < NEUTRAL_L) && (mag_y < NEUTRAL_L);

    // Direction code doubles as the sw bit index: 0=+X 1=+Y 2=-X 3=-Y.
    assign dir = x_wins ? (raw_x[7] ? 2'd2 : 2'd0)
                        : (raw_y[7] ? 2'd3 : 2'd1);

    for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
        assign cand_onehot[gi] = (cand_reg == 2'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cand_reg  <= 2'd0;
            hold_reg  <= 4'd0;
            pulse_reg <= 8'd0;
            sw_reg    <= 4'd0;
            count_reg <= 8'd0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.sample_valid && tilted) begin
                        cand_reg  <= dir;
                        hold_reg  <= 4'd1;
                        state_reg <= QUALIFY;
                    end
                end

                QUALIFY: begin
                    if (bus.sample_valid) begin
                        if (!tilted) begin
                            hold_reg  <= 4'd0;
                            state_reg <= IDLE;
                        end else if (dir != cand_reg) begin
                            cand_reg <= dir;
                            hold_reg <= 4'd1;
                        end else if (hold_reg + 4'd1 == HOLD_L) begin
                            hold_reg  <= 4'd0;
                            pulse_reg <= PULSE_L;
                            sw_reg    <= cand_onehot;
                            count_reg <= count_reg + 8'd1;
                            busy_reg  <= 1'b1;
                            state_reg <= EMIT;
                        end else begin
                            hold_reg <= hold_reg + 4'd1;
                        end
                    end
                end

                EMIT: begin
                    // Counter reads 1 on the last one-hot cycle, giving exactly PULSE_CYCLES.
                    if (pulse_reg == 8'd1) begin
                        pulse_reg <= 8'd0;
                        sw_reg    <= 4'd0;
                        state_reg <= RELEASE;
                    end else begin
                        pulse_reg <= pulse_reg - 8'd1;
                    end
                end

                RELEASE: begin
                    sw_reg <= 4'd0;
                    if (bus.sample_valid && neutral) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    sw_reg    <= 4'd0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sw            = sw_reg;
    assign bus.gesture_count = count_reg;
    assign bus.busy          = busy_reg;
endmodule

// File: tb/tb_tilt_gesture_encoder.sv
// Directed bench for tilt_gesture_encoder: expected pulses are queued as the
// stimulus is driven and matched when each sw pulse completes.
module tb_tilt_gesture_encoder;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    tilt_gesture_if bus();

    tilt_gesture_encoder #(
        .THRESH(40),
        .HYST(8),
        .HOLD_SAMPLES(4),
        .PULSE_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    typedef struct {
        logic [3:0] sw;
        int         len;
        logic [7:0] gc;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         exp_gc = 0;
    logic       in_pulse = 1'b0;
    logic [3:0] pulse_sw;
    int         pulse_len;
    logic [7:0] pulse_gc;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic monitor_step();
        exp_t e;
        if (bus.sw != 4'd0) begin
            if (!in_pulse) begin
                in_pulse  = 1'b1;
                pulse_sw  = bus.sw;
                pulse_len = 1;
                pulse_gc  = bus.gesture_count;
            end else begin
                pulse_len++;
                check("sw_steady", int'(bus.sw), int'(pulse_sw));
            end
        end else if (in_pulse) begin
            in_pulse = 1'b0;
            $display("pulse sw=%b len=%0d gesture_count=%0d", pulse_sw, pulse_len, pulse_gc);
            check("sb_has_entry", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pulse_sw", int'(pulse_sw), int'(e.sw));
                check("pulse_len", pulse_len, e.len);
                check("pulse_gc", int'(pulse_gc), int'(e.gc));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic sample(input int x, input int y);
        bus.tilt_x       = 8'(x);
        bus.tilt_y       = 8'(y);
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic expect_pulse(input logic [3:0] sw, input int len);
        exp_gc++;
        sb.push_back('{sw: sw, len: len, gc: 8'(exp_gc)});
    endtask

    task automatic gesture(input int x, input int y, input logic [3:0] sw);
        repeat (3) sample(x, y);
        expect_pulse(sw, 16);
        sample(x, y);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        exp_gc = 0;
    endtask

    initial begin
        int gap;
        bus.sample_valid = 1'b0;
        bus.tilt_x       = 8'sd0;
        bus.tilt_y       = 8'sd0;
        reset            = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_sw", int'(bus.sw), 0);
        check("rst_gc", int'(bus.gesture_count), 0);
        check("rst_busy", int'(bus.busy), 0);

        // Basic gesture
        do_reset();
        repeat (3) sample(50, 0);
        check("t1_no_early", int'(bus.sw), 0);
        expect_pulse(4'b0001, 16);
        sample(50, 0);
        check("t1_sw", int'(bus.sw), 1);
        check("t1_gc", int'(bus.gesture_count), exp_gc);
        check("t1_busy", int'(bus.busy), 1);
        idle(20);
        check("t1_release_busy", int'(bus.busy), 1);
        check("t1_release_sw", int'(bus.sw), 0);
        sample(0, 0);
        check("t1_neutral_busy", int'(bus.busy), 0);

        // Magnitude and tie handling
        do_reset();
        repeat (2) sample(0, 0);
        gesture(-128, 0, 4'b0100);
        idle(20);
        sample(0, 0);
        gesture(45, -45, 4'b0001);
        idle(20);
        sample(0, 0);
        gesture(30, -60, 4'b1000);
        check("t2_gc", int'(bus.gesture_count), 3);
        idle(20);
        sample(0, 0);

        // Qualify breaks
        do_reset();
        repeat (3) sample(0, 50);
        sample(0, 20);
        check("t3_break_sw", int'(bus.sw), 0);
        check("t3_break_busy", int'(bus.busy), 0);
        repeat (3) sample(0, 50);
        repeat (3) sample(-50, 0);
        check("t3_redirect_wait", int'(bus.sw), 0);
        expect_pulse(4'b0100, 16);
        sample(-50, 0);
        check("t3_redirect_sw", int'(bus.sw), 4);
        idle(20);
        sample(0, 0);

        // Release hysteresis
        do_reset();
        for (int i = 0; i < 100; i++) begin
            if (i == 3) expect_pulse(4'b0010, 16);
            sample(0, 50);
        end
        check("t4_gc1", int'(bus.gesture_count), 1);
        repeat (10) sample(0, 35);
        check("t4_band_busy", int'(bus.busy), 1);
        check("t4_band_sw", int'(bus.sw), 0);
        sample(0, 10);
        check("t4_neutral_busy", int'(bus.busy), 0);
        gesture(0, 50, 4'b0010);
        check("t4_gc2", int'(bus.gesture_count), 2);
        idle(20);
        sample(0, 0);

        // Sparse strobes with tilt_y toggling between them
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) expect_pulse(4'b1000, 16);
            sample(0, -60);
            if (i < 3) begin
                gap = int'($urandom_range(3, 7));
                repeat (gap) begin
                    bus.tilt_y = 8'($urandom_range(0, 255));
                    tick();
                end
                check("t5_sparse_wait", int'(bus.sw), 0);
            end
        end
        check("t5_sw", int'(bus.sw), 8);
        idle(20);
        sample(0, 0);

        // Reset mid-pulse
        do_reset();
        repeat (3) sample(50, 0);
        expect_pulse(4'b0001, 5);
        sample(50, 0);
        idle(4);
        reset = 1'b1;
        tick();
        check("t6_rst_sw", int'(bus.sw), 0);
        check("t6_rst_gc", int'(bus.gesture_count), 0);
        check("t6_rst_busy", int'(bus.busy), 0);
        reset  = 1'b0;
        exp_gc = 0;
        repeat (3) sample(50, 0);
        check("t6_requalify_wait", int'(bus.sw), 0);
        expect_pulse(4'b0001, 16);
        sample(50, 0);
        check("t6_sw", int'(bus.sw), 1);
        check("t6_gc", int'(bus.gesture_count), 1);
        idle(20);

        check("sb_drained", sb.size(), 0);
        check("no_open_pulse", int'(in_pulse), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
